// File: rtl/l1_port_arbiter.sv
// -----------------------------------------------------------------------------
// l1_port_arbiter
//
// Shares a single L1 memory port among N_CORES application cores. Every core
// presents the same single-ID AXI-like interface. The L1 side carries an ID
// that equals the granted core index.
//
// Read path
//   - AR requests are granted round-robin. The search starts one past the
//     last granted core.
//   - Each core may have at most one read burst outstanding.
//   - A stalled AR is locked onto its selected core, so the L1 side never sees
//     the request change or withdraw.
//   - R beats are steered back to the core named by l1_rid.
//   - A beat whose ID has no outstanding burst is accepted and dropped, and it
//     sets the sticky rid_err flag.
//
// Write path
//   - All writes are single beats, with AW and W presented together by a core.
//   - One write is in flight at a time. The grant is held from AW/W issue
//     until the B handshake.
//   - c_awready and c_wready pulse together once both L1 handshakes are done.
//
// Ports
//   ap_clk, ap_rst            clock, synchronous active-high reset
//   c_ar*, c_r*               per-core read address / read data channels
//   c_aw*, c_w*, c_b*         per-core write address / data / response
//   l1_ar*, l1_r*             shared L1 read channels (ID = core index)
//   l1_aw*, l1_w*, l1_b*      shared L1 write channels
//   rid_err                   sticky flag: R beat arrived for an idle ID
//
// Optional build macro
//   L1_ARB_PERF_EN adds two per-core performance counters:
//     perf_rd_stall   saturating count of cycles with c_arvalid high and
//                     c_arready low
//     perf_wr_grants  count of completed writes
// -----------------------------------------------------------------------------
module l1_port_arbiter #(
  parameter int N_CORES = 4,
  parameter int ID_W    = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  // core read address
  input  logic [N_CORES-1:0]      c_arvalid,
  output logic [N_CORES-1:0]      c_arready,
  input  logic [N_CORES*32-1:0]   c_araddr,
  input  logic [N_CORES*8-1:0]    c_arlen,
  // core read data
  output logic [N_CORES-1:0]      c_rvalid,
  input  logic [N_CORES-1:0]      c_rready,
  output logic [31:0]             c_rdata,
  output logic                    c_rlast,
  // core write address / data / response
  input  logic [N_CORES-1:0]      c_awvalid,
  output logic [N_CORES-1:0]      c_awready,
  input  logic [N_CORES*32-1:0]   c_awaddr,
  input  logic [N_CORES-1:0]      c_wvalid,
  output logic [N_CORES-1:0]      c_wready,
  input  logic [N_CORES*32-1:0]   c_wdata,
  output logic [N_CORES-1:0]      c_bvalid,
  input  logic [N_CORES-1:0]      c_bready,
  // L1 read address
  output logic                    l1_arvalid,
  input  logic                    l1_arready,
  output logic [31:0]             l1_araddr,
  output logic [7:0]              l1_arlen,
  output logic [ID_W-1:0]         l1_arid,
  // L1 read data
  input  logic                    l1_rvalid,
  output logic                    l1_rready,
  input  logic [31:0]             l1_rdata,
  input  logic                    l1_rlast,
  input  logic [ID_W-1:0]         l1_rid,
  // L1 write address / data / response
  output logic                    l1_awvalid,
  input  logic                    l1_awready,
  output logic [31:0]             l1_awaddr,
  output logic [ID_W-1:0]         l1_awid,
  output logic                    l1_wvalid,
  input  logic                    l1_wready,
  output logic [31:0]             l1_wdata,
  output logic                    l1_wlast,
  input  logic                    l1_bvalid,
  output logic                    l1_bready,
  output logic                    rid_err
`ifdef L1_ARB_PERF_EN
  ,
  output logic [N_CORES*32-1:0]   perf_rd_stall,
  output logic [N_CORES*32-1:0]   perf_wr_grants
`endif
);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_SEND = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  genvar gi;

  // Unpack the flat per-core buses so the muxes can index by core number.
  logic [31:0] araddr_arr [N_CORES];
  logic [7:0]  arlen_arr  [N_CORES];
  logic [31:0] awaddr_arr [N_CORES];
  logic [31:0] wdata_arr  [N_CORES];

  generate
    for (gi = 0; gi < N_CORES; gi++) begin : g_unpack
      assign araddr_arr[gi] = c_araddr[gi*32 +: 32];
      assign arlen_arr[gi]  = c_arlen[gi*8 +: 8];
      assign awaddr_arr[gi] = c_awaddr[gi*32 +: 32];
      assign wdata_arr[gi]  = c_wdata[gi*32 +: 32];
    end
  endgenerate

  // Round-robin pick: the first set bit of req, searching from ptr+1 and
  // wrapping. The loop runs from the far end backwards, so the nearest
  // candidate is the last one written and therefore wins.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_CORES-1:0] req,
                                               input logic [ID_W-1:0]    ptr);
    int              idx;
    logic [ID_W-1:0] pick;
    pick = ptr;
    idx  = 0;
    for (int k = N_CORES; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_CORES;
      if (req[idx]) pick = idx[ID_W-1:0];
    end
    return pick;
  endfunction

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [N_CORES-1:0] rd_pending_reg, rd_pending_next;
  logic [ID_W-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [ID_W-1:0]    ar_sel_reg, ar_sel_next;
  logic               ar_lock_reg, ar_lock_next;
  logic               rid_err_reg, rid_err_next;

  logic [N_CORES-1:0] rd_elig;
  logic [ID_W-1:0]    rd_win;
  logic [ID_W-1:0]    rd_sel;
  logic               ar_fire;
  logic               rid_in_range;
  logic               rid_pending;
  logic               r_fire;

  // Eligibility uses the registered pending bits. A core whose last beat
  // lands this cycle therefore cannot be re-granted until the next cycle.
  assign rd_elig = c_arvalid & ~rd_pending_reg;
  assign rd_win  = rr_pick(rd_elig, rd_ptr_reg);
  assign rd_sel  = ar_lock_reg ? ar_sel_reg : rd_win;

  assign l1_arvalid = !ap_rst && (ar_lock_reg || (|rd_elig));
  assign ar_fire    = l1_arvalid && l1_arready;
  assign l1_araddr  = araddr_arr[rd_sel];
  assign l1_arlen   = arlen_arr[rd_sel];
  assign l1_arid    = rd_sel;

  generate
    for (gi = 0; gi < N_CORES; gi++) begin : g_arready
      assign c_arready[gi] = ar_fire && (int'(rd_sel) == gi);
    end
  endgenerate

  // An ID outside the core range (possible when N_CORES is not a power of
  // two) is handled exactly like an ID with no outstanding burst.
  assign rid_in_range = (int'(l1_rid) < N_CORES);
  assign rid_pending  = rid_in_range && rd_pending_reg[l1_rid];

  // Stray beats are always accepted, so a bad ID cannot wedge the L1 port.
  assign l1_rready = !ap_rst && (rid_pending ? c_rready[l1_rid] : 1'b1);
  assign r_fire    = l1_rvalid && l1_rready;
  assign c_rdata   = l1_rdata;
  assign c_rlast   = l1_rlast;

  generate
    for (gi = 0; gi < N_CORES; gi++) begin : g_rvalid
      assign c_rvalid[gi] = !ap_rst && l1_rvalid && rid_pending &&
                            (int'(l1_rid) == gi);
    end
  endgenerate

  always_comb begin
    rd_pending_next = rd_pending_reg;
    rd_ptr_next     = rd_ptr_reg;
    ar_lock_next    = ar_lock_reg;
    ar_sel_next     = ar_sel_reg;
    rid_err_next    = rid_err_reg;

    if (ar_fire) begin
      rd_pending_next[rd_sel] = 1'b1;
      rd_ptr_next             = rd_sel;
      ar_lock_next            = 1'b0;
    end else if (l1_arvalid && !ar_lock_reg) begin
      // Freeze the choice so the stalled request stays stable.
      ar_lock_next = 1'b1;
      ar_sel_next  = rd_win;
    end

    // The granted core is never pending, so this clear cannot collide with
    // the set above.
    if (r_fire && l1_rlast && rid_pending) rd_pending_next[l1_rid] = 1'b0;

    if (l1_rvalid && !rid_pending) rid_err_next = 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rd_pending_reg <= '0;
      rd_ptr_reg     <= '0;
      ar_sel_reg     <= '0;
      ar_lock_reg    <= 1'b0;
      rid_err_reg    <= 1'b0;
    end else begin
      rd_pending_reg <= rd_pending_next;
      rd_ptr_reg     <= rd_ptr_next;
      ar_sel_reg     <= ar_sel_next;
      ar_lock_reg    <= ar_lock_next;
      rid_err_reg    <= rid_err_next;
    end
  end

  assign rid_err = rid_err_reg;

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  wr_state_t          wr_state_reg, wr_state_next;
  logic [ID_W-1:0]    wr_sel_reg, wr_sel_next;
  logic [ID_W-1:0]    wr_ptr_reg, wr_ptr_next;
  logic               aw_done_reg, aw_done_next;
  logic               w_done_reg, w_done_next;

  logic [N_CORES-1:0] wr_elig;
  logic [ID_W-1:0]    wr_win;
  logic               aw_fire;
  logic               w_fire;
  logic               send_done;
  logic               b_fire;

  assign wr_elig = c_awvalid & c_wvalid;
  assign wr_win  = rr_pick(wr_elig, wr_ptr_reg);

  // State register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wr_state_reg <= W_IDLE;
      wr_sel_reg   <= '0;
      wr_ptr_reg   <= '0;
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
    end else begin
      wr_state_reg <= wr_state_next;
      wr_sel_reg   <= wr_sel_next;
      wr_ptr_reg   <= wr_ptr_next;
      aw_done_reg  <= aw_done_next;
      w_done_reg   <= w_done_next;
    end
  end

  // Output logic for the L1 write side
  always_comb begin
    l1_awvalid = 1'b0;
    l1_wvalid  = 1'b0;
    l1_bready  = 1'b0;
    if (!ap_rst) begin
      case (wr_state_reg)
        W_SEND: begin
          // Each valid drops independently once its own handshake is done.
          l1_awvalid = !aw_done_reg;
          l1_wvalid  = !w_done_reg;
        end
        W_RESP:  l1_bready = c_bready[wr_sel_reg];
        default: ;
      endcase
    end
  end

  assign aw_fire   = l1_awvalid && l1_awready;
  assign w_fire    = l1_wvalid && l1_wready;
  assign send_done = !ap_rst && (wr_state_reg == W_SEND) &&
                     (aw_done_reg || aw_fire) && (w_done_reg || w_fire);
  assign b_fire    = l1_bvalid && l1_bready;

  assign l1_awaddr = awaddr_arr[wr_sel_reg];
  assign l1_awid   = wr_sel_reg;
  assign l1_wdata  = wdata_arr[wr_sel_reg];
  assign l1_wlast  = 1'b1;

  generate
    for (gi = 0; gi < N_CORES; gi++) begin : g_wr_route
      // The core sees a single joint AW/W acceptance once both L1 sides are done.
      assign c_awready[gi] = send_done && (int'(wr_sel_reg) == gi);
      assign c_wready[gi]  = send_done && (int'(wr_sel_reg) == gi);
      assign c_bvalid[gi]  = !ap_rst && (wr_state_reg == W_RESP) && l1_bvalid &&
                             (int'(wr_sel_reg) == gi);
    end
  endgenerate

  // Next-state logic
  always_comb begin
    wr_state_next = wr_state_reg;
    wr_sel_next   = wr_sel_reg;
    wr_ptr_next   = wr_ptr_reg;
    aw_done_next  = aw_done_reg;
    w_done_next   = w_done_reg;
    case (wr_state_reg)
      W_IDLE: begin
        if (|wr_elig) begin
          wr_sel_next   = wr_win;
          aw_done_next  = 1'b0;
          w_done_next   = 1'b0;
          wr_state_next = W_SEND;
        end
      end
      W_SEND: begin
        if (aw_fire) aw_done_next = 1'b1;
        if (w_fire)  w_done_next  = 1'b1;
        if (send_done) wr_state_next = W_RESP;
      end
      W_RESP: begin
        if (b_fire) begin
          // The pointer advances only when the write fully completes.
          wr_ptr_next   = wr_sel_reg;
          wr_state_next = W_IDLE;
        end
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef L1_ARB_PERF_EN
  generate
    for (gi = 0; gi < N_CORES; gi++) begin : g_perf
      logic [31:0] stall_cnt_reg;
      logic [31:0] grant_cnt_reg;

      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          stall_cnt_reg <= '0;
          grant_cnt_reg <= '0;
        end else begin
          if (c_arvalid[gi] && !c_arready[gi] && (stall_cnt_reg != 32'hFFFF_FFFF))
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
          if (b_fire && (int'(wr_sel_reg) == gi))
            grant_cnt_reg <= grant_cnt_reg + 32'd1;
        end
      end

      assign perf_rd_stall[gi*32 +: 32]  = stall_cnt_reg;
      assign perf_wr_grants[gi*32 +: 32] = grant_cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_l1_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_l1_port_arbiter
//
// Random cores and a random L1 responder drive the arbiter. A transaction-level
// reference model (request flags, pending set, per-core beat counters and a
// single write-in-flight record) predicts every handshake cycle by cycle.
// Directed steps cover reset behaviour and the sticky stray-RID flag.
// -----------------------------------------------------------------------------
module tb_l1_port_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic              ap_clk = 1'b0;
  logic              ap_rst;
  logic [N-1:0]      c_arvalid, c_arready, c_rvalid, c_rready;
  logic [N*32-1:0]   c_araddr, c_awaddr, c_wdata;
  logic [N*8-1:0]    c_arlen;
  logic [31:0]       c_rdata;
  logic              c_rlast;
  logic [N-1:0]      c_awvalid, c_awready, c_wvalid, c_wready, c_bvalid, c_bready;
  logic              l1_arvalid, l1_arready, l1_rvalid, l1_rready, l1_rlast;
  logic [31:0]       l1_araddr, l1_rdata, l1_awaddr, l1_wdata;
  logic [7:0]        l1_arlen;
  logic [IW-1:0]     l1_arid, l1_rid, l1_awid;
  logic              l1_awvalid, l1_awready, l1_wvalid, l1_wready, l1_wlast;
  logic              l1_bvalid, l1_bready, rid_err;

  l1_port_arbiter #(.N_CORES(N)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .c_arvalid(c_arvalid), .c_arready(c_arready), .c_araddr(c_araddr), .c_arlen(c_arlen),
    .c_rvalid(c_rvalid), .c_rready(c_rready), .c_rdata(c_rdata), .c_rlast(c_rlast),
    .c_awvalid(c_awvalid), .c_awready(c_awready), .c_awaddr(c_awaddr),
    .c_wvalid(c_wvalid), .c_wready(c_wready), .c_wdata(c_wdata),
    .c_bvalid(c_bvalid), .c_bready(c_bready),
    .l1_arvalid(l1_arvalid), .l1_arready(l1_arready), .l1_araddr(l1_araddr),
    .l1_arlen(l1_arlen), .l1_arid(l1_arid),
    .l1_rvalid(l1_rvalid), .l1_rready(l1_rready), .l1_rdata(l1_rdata),
    .l1_rlast(l1_rlast), .l1_rid(l1_rid),
    .l1_awvalid(l1_awvalid), .l1_awready(l1_awready), .l1_awaddr(l1_awaddr), .l1_awid(l1_awid),
    .l1_wvalid(l1_wvalid), .l1_wready(l1_wready), .l1_wdata(l1_wdata), .l1_wlast(l1_wlast),
    .l1_bvalid(l1_bvalid), .l1_bready(l1_bready), .rid_err(rid_err)
  );

  always #5 ap_clk = ~ap_clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model state ----------------
  bit          req[N];          // core holds an AR request
  logic [31:0] req_addr[N];
  logic [7:0]  req_len[N];
  bit          pend[N];         // core has a read burst outstanding
  int          lbeats[N];       // beats the L1 responder still owes each core
  int          rptr;
  bit          lock;
  int          lock_sel;
  bit          rb_v;            // L1 is presenting an R beat
  int          rb_id;
  logic [31:0] rb_data;
  bit          wbusy[N];        // core is waiting for its write to finish
  bit          wreq[N];         // core is presenting AW/W
  logic [31:0] wa[N], wd[N];
  int          wcur;            // core owning the write port, -1 when free
  bit          wresp;           // write owner is in its response phase
  int          wptr;
  bit          aw_got, w_got, bv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] hs_vec();
    return {l1_arvalid, l1_awvalid, l1_wvalid, l1_rready, l1_bready,
            c_arready, c_rvalid, c_awready, c_wready, c_bvalid};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      req[i] = 0; pend[i] = 0; lbeats[i] = 0; wbusy[i] = 0; wreq[i] = 0;
      req_addr[i] = '0; req_len[i] = '0; wa[i] = '0; wd[i] = '0;
    end
    rptr = 0; lock = 0; lock_sel = 0; rb_v = 0; rb_id = 0; rb_data = '0;
    wcur = -1; wresp = 0; wptr = 0; aw_got = 0; w_got = 0; bv = 0;
  endtask

  task automatic idle_inputs();
    c_arvalid = '0; c_awvalid = '0; c_wvalid = '0; c_rready = '0; c_bready = '0;
    c_araddr = '0; c_arlen = '0; c_awaddr = '0; c_wdata = '0;
    l1_arready = 0; l1_rvalid = 0; l1_rdata = '0; l1_rlast = 0; l1_rid = '0;
    l1_awready = 0; l1_wready = 0; l1_bvalid = 0;
  endtask

  // Reset for two edges with every incoming valid/ready high.
  task automatic do_reset();
    @(posedge ap_clk); #1;
    ap_rst = 1;
    c_arvalid = '1; c_awvalid = '1; c_wvalid = '1; c_rready = '1; c_bready = '1;
    l1_arready = 1; l1_rvalid = 1; l1_awready = 1; l1_wready = 1; l1_bvalid = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge ap_clk);
      chk("reset_handshakes", 64'(hs_vec()), 64'(0));
      if (c == 1) chk("reset_rid_err", 64'(rid_err), 64'(0));
      @(posedge ap_clk); #1;
    end
    ap_rst = 0;
    idle_inputs();
    model_clear();
  endtask

  // One clock of random traffic: drive, predict, check, advance the model.
  task automatic step(input bit quiet);
    int           cand[$];
    int           j;
    bit           exp_v;
    int           exp_sel;
    logic [N-1:0] oh;
    bit           exp_awv, exp_wv, aw_now, w_now, pulse;

    @(posedge ap_clk); #1;
    for (int i = 0; i < N; i++) begin
      if (!quiet && !req[i] && $urandom_range(0, 3) == 0) begin
        req[i] = 1;
        req_addr[i] = $urandom() & 32'hFFFF_FFFC;
        req_len[i] = 8'($urandom_range(0, 3));
      end
      if (!quiet && !wbusy[i] && $urandom_range(0, 4) == 0) begin
        wbusy[i] = 1; wreq[i] = 1; wa[i] = $urandom(); wd[i] = $urandom();
      end
    end
    if (!rb_v && (quiet || $urandom_range(0, 1) == 1)) begin
      for (int i = 0; i < N; i++) if (lbeats[i] > 0) cand.push_back(i);
      if (cand.size() > 0) begin
        rb_v = 1;
        rb_id = cand[$urandom_range(0, cand.size() - 1)];
        rb_data = $urandom();
      end
    end
    if (wcur >= 0 && wresp && !bv && (quiet || $urandom_range(0, 2) == 0)) bv = 1;

    for (int i = 0; i < N; i++) begin
      c_arvalid[i] = req[i];
      c_araddr[i*32 +: 32] = req_addr[i];
      c_arlen[i*8 +: 8] = req_len[i];
      c_awvalid[i] = wreq[i];
      c_wvalid[i] = wreq[i];
      c_awaddr[i*32 +: 32] = wa[i];
      c_wdata[i*32 +: 32] = wd[i];
    end
    l1_arready = quiet ? 1'b1 : 1'($urandom_range(0, 1));
    c_rready   = quiet ? '1 : N'($urandom());
    c_bready   = N'($urandom());
    l1_awready = quiet ? 1'b1 : 1'($urandom_range(0, 1));
    l1_wready  = quiet ? 1'b1 : 1'($urandom_range(0, 1));
    l1_bvalid  = bv;
    l1_rvalid  = rb_v;
    l1_rid     = rb_id[IW-1:0];
    l1_rdata   = rb_data;
    l1_rlast   = rb_v && (lbeats[rb_id] == 1);

    @(negedge ap_clk);
    // ---- read address: locked request, else round-robin from rptr+1 ----
    exp_v = 0; exp_sel = 0;
    if (lock) begin
      exp_v = 1; exp_sel = lock_sel;
    end else begin
      for (int k = 1; k <= N; k++) begin
        j = (rptr + k) % N;
        if (!exp_v && req[j] && !pend[j]) begin exp_v = 1; exp_sel = j; end
      end
    end
    chk("l1_arvalid", 64'(l1_arvalid), 64'(exp_v));
    if (exp_v)
      chk("ar_fields", 64'({l1_arid, l1_arlen, l1_araddr}),
          64'({2'(exp_sel), req_len[exp_sel], req_addr[exp_sel]}));
    oh = '0;
    if (exp_v && l1_arready) oh[exp_sel] = 1'b1;
    chk("c_arready", 64'(c_arready), 64'(oh));

    // ---- read data routing ----
    oh = '0;
    if (rb_v) oh[rb_id] = 1'b1;
    chk("c_rvalid", 64'(c_rvalid), 64'(oh));
    if (rb_v)
      chk("r_route", 64'({l1_rready, c_rlast, c_rdata}),
          64'({c_rready[rb_id], (lbeats[rb_id] == 1), rb_data}));
    chk("rid_err_quiet", 64'(rid_err), 64'(0));

    // ---- write ----
    exp_awv = (wcur >= 0) && !wresp && !aw_got;
    exp_wv  = (wcur >= 0) && !wresp && !w_got;
    chk("l1_aw_w_valid", 64'({l1_awvalid, l1_wvalid}), 64'({exp_awv, exp_wv}));
    if (wcur >= 0 && !wresp)
      chk("aw_w_fields", 64'({l1_awid, l1_wlast, l1_awaddr}),
          64'({2'(wcur), 1'b1, wa[wcur]}));
    if (wcur >= 0 && !wresp) chk("l1_wdata", 64'(l1_wdata), 64'(wd[wcur]));
    aw_now = aw_got || (exp_awv && l1_awready);
    w_now  = w_got  || (exp_wv && l1_wready);
    pulse  = (wcur >= 0) && !wresp && aw_now && w_now;
    oh = '0;
    if (pulse) oh[wcur] = 1'b1;
    chk("c_aw_w_ready", 64'({c_awready, c_wready}), 64'({oh, oh}));
    oh = '0;
    if (wcur >= 0 && wresp && bv) oh[wcur] = 1'b1;
    chk("c_bvalid", 64'(c_bvalid), 64'(oh));
    chk("l1_bready", 64'(l1_bready),
        64'((wcur >= 0 && wresp) ? c_bready[wcur] : 1'b0));

    // ---- advance model ----
    if (exp_v && l1_arready) begin
      $display("AR  core %0d addr %08h len %0d", exp_sel, req_addr[exp_sel], req_len[exp_sel]);
      req[exp_sel] = 0; pend[exp_sel] = 1; rptr = exp_sel; lock = 0;
      lbeats[exp_sel] = int'(req_len[exp_sel]) + 1;
    end else if (exp_v && !lock) begin
      lock = 1; lock_sel = exp_sel;
    end
    if (rb_v && c_rready[rb_id]) begin
      lbeats[rb_id]--;
      if (lbeats[rb_id] == 0) begin
        pend[rb_id] = 0;
        $display("R   core %0d last beat %08h", rb_id, rb_data);
      end
      rb_v = 0;
    end
    if (wcur < 0) begin
      for (int k = 1; k <= N; k++) begin
        j = (wptr + k) % N;
        if (wcur < 0 && wreq[j]) wcur = j;
      end
      aw_got = 0; w_got = 0; wresp = 0; bv = 0;
    end else if (!wresp) begin
      aw_got = aw_now; w_got = w_now;
      if (pulse) begin wresp = 1; wreq[wcur] = 0; end
    end else if (bv && c_bready[wcur]) begin
      $display("WR  core %0d addr %08h data %08h", wcur, wa[wcur], wd[wcur]);
      wbusy[wcur] = 0; wptr = wcur; wcur = -1; bv = 0;
    end
  endtask

  initial begin
    ap_rst = 1;
    idle_inputs();
    model_clear();
    do_reset();

    // Random traffic, then a quiet tail that drains every outstanding burst.
    for (int cyc = 0; cyc < 500; cyc++) step(cyc >= 420);

    // Stray beat for core 2, which has nothing outstanding.
    @(posedge ap_clk); #1;
    idle_inputs();
    l1_rvalid = 1; l1_rid = 2'd2; l1_rlast = 1; l1_rdata = 32'hDEAD_BEEF;
    @(negedge ap_clk);
    chk("stray_rready", 64'(l1_rready), 64'(1));
    chk("stray_err_before", 64'(rid_err), 64'(0));
    $display("R   stray beat id 2");
    @(posedge ap_clk); #1;
    l1_rvalid = 0; l1_rlast = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge ap_clk);
      chk("stray_err_sticky", 64'(rid_err), 64'(1));
    end

    // Reset clears the sticky flag.
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
